toggle_edge_capture: RTL and testbench
======================================

Name: toggle_edge_capture

Overview:
- Downstream consumer of a free-running toggle flop (a flop that loads its own inverse every clock).
- Detects every transition of the toggle signal, counts the transitions, and captures a sign-extended sample of a signed data input on each transition.
- Delivers each captured sample over a valid/ready handshake and keeps a sticky overrun flag.
- Every state flop has a declared power-up initialiser equal to its reset value, so init-attribute handling and async reset agree in synthesis and equivalence checks.

Parameters:
- IN_W, 1, width of the signed sample input din.
- OUT_W, 2, width of the captured output. Must be >= IN_W; din is sign-extended to this width.
- CNT_W, 4, width of the transition counter.
- SATURATE, 0, counter mode: 0 = wrap at 2^CNT_W, 1 = hold at all-ones.
- PREV_INIT, 0, power-up/reset value of the toggle-history flop.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- tog_in  input  1  toggle signal from the upstream flop, already in the clk domain.
- din  input  IN_W  signed sample, captured on a transition.
- clr  input  1  synchronous clear of count and overrun.
- out_ready  input  1  consumer accepts out_data.
- edge_pulse  output  1  registered, high for one cycle after each detected transition.
- count  output  CNT_W  number of transitions seen.
- out_valid  output  1  out_data holds an unconsumed sample.
- out_data  output  OUT_W  sign-extended captured sample.
- overrun  output  1  sticky flag: a sample was dropped.

Behaviour:
- Reset (rst_n low, asynchronous, any cycle, including mid-handshake):
  - prev = PREV_INIT; edge_pulse = 0; count = 0; out_valid = 0; out_data = 0; overrun = 0.
  - Outputs change immediately on reset assertion, not at the next clock.
  - Initialisers carry the same values.
- Edge detect:
  - edge = tog_in XOR prev; prev <= tog_in every cycle.
  - edge_pulse <= edge, giving 1-cycle latency from the tog_in change.
  - With a dff-style toggler on tog_in, edge_pulse is high every cycle from the second cycle after reset release (the first cycle only if tog_in's reset value differs from PREV_INIT).
- Counter:
  - On edge: count <= count + 1, CNT_W wide.
  - SATURATE=0: wraps from all-ones to 0.
  - SATURATE=1: stays at all-ones.
  - clr has priority over edge in the same cycle: count <= 0, and that edge is not counted.
- Capture/handshake, two states, EMPTY (out_valid=0) and FULL (out_valid=1):
  - EMPTY and edge: out_data <= sign-extended din, go to FULL.
  - FULL and out_ready and edge: out_data <= new sample, stay FULL (simultaneous accept and reload, no bubble).
  - FULL and out_ready and no edge: go to EMPTY; out_data holds its last value.
  - FULL and not out_ready and edge: out_data unchanged (oldest sample kept), overrun <= 1.
  - out_data and out_valid must not change while out_valid=1 and out_ready=0.
- Sign extension:
  - out_data = {(OUT_W-IN_W){din[IN_W-1]}, din}.
  - With IN_W=1, OUT_W=2: din=1 gives out_data=2'b11.
  - Zero-extension is a failure.
- overrun is cleared only by clr or reset. If clr and a new overrun condition occur in the same cycle, clr wins and overrun = 0.
- No combinational path from any input to any output.

Test Plan:
- Reset release, PREV_INIT=0, tog_in driven by a dff0-style toggler, out_ready=1 -> edge_pulse high every cycle from cycle 2; count reads 1,2,3,... and wraps 15->0 at CNT_W=4.
- IN_W=1, OUT_W=2, din=1 on a transition, out_ready=0 -> out_valid=1, out_data=2'b11; din=0 on the next capture after a drain -> out_data=2'b00.
- out_ready=0 held across two transitions (first din=1, second din=0) -> out_data stays 2'b11, overrun=1, out_valid=1; raise out_ready with no edge -> out_valid=0 next cycle; overrun stays 1 until clr.
- FULL with out_ready=1 and an edge in the same cycle -> out_valid stays 1, out_data updates to the new sample, overrun stays 0.
- SATURATE=1, 20 transitions -> count=4'hF and held; clr asserted together with an edge -> count=0.
- rst_n pulsed low mid-stream between clock edges -> all outputs 0 immediately; after release, behaviour matches the first scenario.

Source files
------------

// File: rtl/toggle_edge_capture.sv
`default_nettype none
// ============================================================================
//  Module   : toggle_edge_capture
//  Purpose  : Consumer of a free-running toggle flop. It detects every
//             transition of tog_in, counts the transitions, and captures a
//             sign-extended sample of din on each one. Samples are delivered
//             through a one-entry valid/ready output register. A sticky
//             overrun flag records any sample dropped because the register
//             was still occupied.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1      rising-edge clock
//    rst_n      in   1      asynchronous active-low reset
//    tog_in     in   1      toggle signal, already synchronous to clk
//    din        in   IN_W   signed sample, captured on a transition
//    clr        in   1      synchronous clear of count and overrun
//    out_ready  in   1      consumer accepts out_data
//    edge_pulse out  1      one-cycle pulse, one clock after a transition
//    count      out  CNT_W  number of transitions seen
//    out_valid  out  1      out_data holds an unconsumed sample
//    out_data   out  OUT_W  sign-extended captured sample
//    overrun    out  1      sticky: a sample was dropped
// ============================================================================
module toggle_edge_capture #(
   parameter int   IN_W      = 1,
   parameter int   OUT_W     = 2,
   parameter int   CNT_W     = 4,
   parameter int   SATURATE  = 0,
   parameter logic PREV_INIT = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tog_in,
   input  logic [IN_W-1:0]  din,
   input  logic             clr,
   input  logic             out_ready,
   output logic             edge_pulse,
   output logic [CNT_W-1:0] count,
   output logic             out_valid,
   output logic [OUT_W-1:0] out_data,
   output logic             overrun
);

   typedef enum logic [0:0] {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   // Every flop carries a power-up value identical to its reset value.
   state_t             state      = EMPTY;
   logic               prev       = PREV_INIT;
   logic               pulse_q    = 1'b0;
   logic [CNT_W-1:0]   count_q    = '0;
   logic [OUT_W-1:0]   data_q     = '0;
   logic               overrun_q  = 1'b0;

   state_t             next_state;
   logic               load;
   logic               drop;
   logic               tog_edge;
   logic [CNT_W-1:0]   count_nxt;
   logic [OUT_W-1:0]   din_ext;

   assign tog_edge = tog_in ^ prev;

   // Sign extension; the equal-width case needs no replication.
   if (OUT_W > IN_W) begin : g_sext
      assign din_ext = {{(OUT_W-IN_W){din[IN_W-1]}}, din};
   end else begin : g_same_width
      assign din_ext = din;
   end

   // ------------------------------------------------------------------
   // Handshake FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= EMPTY;
      end else begin
         state <= next_state;
      end
   end

   // ------------------------------------------------------------------
   // Handshake FSM: next state and capture decisions
   // ------------------------------------------------------------------
   always_comb begin
      next_state = state;
      load       = 1'b0;
      drop       = 1'b0;
      case (state)
         EMPTY: begin
            if (tog_edge) begin
               load       = 1'b1;
               next_state = FULL;
            end
         end
         FULL: begin
            if (out_ready) begin
               // Accept and reload in the same cycle keeps the slot full
               // without a bubble.
               if (tog_edge) begin
                  load = 1'b1;
               end else begin
                  next_state = EMPTY;
               end
            end else if (tog_edge) begin
               // Slot occupied and not consumed: the oldest sample is kept.
               drop = 1'b1;
            end
         end
         default: next_state = EMPTY;
      endcase
   end

   // ------------------------------------------------------------------
   // Transition counter next value
   // ------------------------------------------------------------------
   always_comb begin
      count_nxt = count_q;
      if (clr) begin
         count_nxt = '0;
      end else if (tog_edge) begin
         if ((SATURATE != 0) && (&count_q)) begin
            count_nxt = count_q;
         end else begin
            count_nxt = count_q + 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Datapath and status registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev      <= PREV_INIT;
         pulse_q   <= 1'b0;
         count_q   <= '0;
         data_q    <= '0;
         overrun_q <= 1'b0;
      end else begin
         prev    <= tog_in;
         pulse_q <= tog_edge;
         count_q <= count_nxt;
         if (load) begin
            data_q <= din_ext;
         end
         // clr wins over a simultaneous drop.
         if (clr) begin
            overrun_q <= 1'b0;
         end else if (drop) begin
            overrun_q <= 1'b1;
         end
      end
   end

   assign edge_pulse = pulse_q;
   assign count      = count_q;
   assign out_valid  = (state == FULL);
   assign out_data   = data_q;
   assign overrun    = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_toggle_edge_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tb_toggle_edge_capture
//  Purpose  : Self-checking bench. Two instances (wrapping and saturating
//             counter) share one stimulus stream; a transaction-level model
//             predicts every output each cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_toggle_edge_capture;

   localparam int IN_W  = 1;
   localparam int OUT_W = 2;
   localparam int CNT_W = 4;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             tog_in = 1'b0;
   logic [IN_W-1:0]  din = '0;
   logic             clr = 1'b0;
   logic             out_ready = 1'b0;

   logic             edge_pulse_w, out_valid_w, overrun_w;
   logic [CNT_W-1:0] count_w;
   logic [OUT_W-1:0] out_data_w;
   logic             edge_pulse_s, out_valid_s, overrun_s;
   logic [CNT_W-1:0] count_s;
   logic [OUT_W-1:0] out_data_s;

   int checks = 0;
   int errors = 0;

   // Reference model state
   bit m_prev;
   bit m_pulse;
   int m_cnt_wrap;
   int m_cnt_sat;
   bit m_valid;
   int m_data;
   bit m_ovr;

   always #5 clk = ~clk;

   toggle_edge_capture #(
      .IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W), .SATURATE(0), .PREV_INIT(1'b0)
   ) u_wrap (
      .clk(clk), .rst_n(rst_n), .tog_in(tog_in), .din(din), .clr(clr),
      .out_ready(out_ready), .edge_pulse(edge_pulse_w), .count(count_w),
      .out_valid(out_valid_w), .out_data(out_data_w), .overrun(overrun_w)
   );

   toggle_edge_capture #(
      .IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W), .SATURATE(1), .PREV_INIT(1'b0)
   ) u_sat (
      .clk(clk), .rst_n(rst_n), .tog_in(tog_in), .din(din), .clr(clr),
      .out_ready(out_ready), .edge_pulse(edge_pulse_s), .count(count_s),
      .out_valid(out_valid_s), .out_data(out_data_s), .overrun(overrun_s)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Signed value of din, re-expressed modulo 2^OUT_W.
   function automatic int sext(input int v);
      int s;
      s = v;
      if (s >= (1 << (IN_W - 1))) s = s - (1 << IN_W);
      return s & ((1 << OUT_W) - 1);
   endfunction

   task automatic model_reset();
      m_prev     = 1'b0;
      m_pulse    = 1'b0;
      m_cnt_wrap = 0;
      m_cnt_sat  = 0;
      m_valid    = 1'b0;
      m_data     = 0;
      m_ovr      = 1'b0;
   endtask

   // One clock edge of the specified behaviour.
   task automatic model_step(input bit t, input int d, input bit c, input bit r);
      bit e;
      e       = (t != m_prev);
      m_pulse = e;
      m_prev  = t;
      if (c) begin
         m_cnt_wrap = 0;
         m_cnt_sat  = 0;
      end else if (e) begin
         m_cnt_wrap = (m_cnt_wrap + 1) % (CMAX + 1);
         m_cnt_sat  = (m_cnt_sat < CMAX) ? m_cnt_sat + 1 : CMAX;
      end
      if (e) begin
         if (!m_valid || r) begin
            m_data  = sext(d);
            m_valid = 1'b1;
         end else begin
            m_ovr = 1'b1;  // slot busy: new sample dropped
         end
      end else if (m_valid && r) begin
         m_valid = 1'b0;
      end
      if (c) m_ovr = 1'b0;
   endtask

   task automatic compare_all();
      check("edge_pulse", edge_pulse_w, m_pulse);
      check("count_wrap", count_w, m_cnt_wrap);
      check("out_valid",  out_valid_w, m_valid);
      check("out_data",   out_data_w, m_data);
      check("overrun",    overrun_w, m_ovr);
      check("count_sat",  count_s, m_cnt_sat);
      check("sat_valid",  out_valid_s, m_valid);
      check("sat_data",   out_data_s, m_data);
      check("sat_ovr",    overrun_s, m_ovr);
      check("sat_pulse",  edge_pulse_s, m_pulse);
   endtask

   // Called at a negedge with inputs already driven.
   task automatic cycle();
      bit t, c, r;
      int d;
      t = tog_in; d = int'(din); c = clr; r = out_ready;
      @(posedge clk);
      model_step(t, d, c, r);
      @(negedge clk);
      compare_all();
   endtask

   task automatic drive(input bit t, input int d, input bit c, input bit r);
      tog_in    = t;
      din       = d[IN_W-1:0];
      clr       = c;
      out_ready = r;
      cycle();
   endtask

   // Emulates a dff toggler released from reset with Q=0.
   task automatic run_toggler(input int n);
      drive(1'b0, $urandom_range(1, 0), 1'b0, 1'b1);
      for (int i = 0; i < n; i++) begin
         drive(~tog_in, $urandom_range(1, 0), 1'b0, 1'b1);
      end
   endtask

   initial begin
      model_reset();
      repeat (2) @(negedge clk);
      compare_all();                       // reset state
      rst_n = 1'b1;

      // Toggler from reset release; count wraps more than once.
      run_toggler(40);

      // Sign extension and overrun handling.
      drive(tog_in, 0, 1'b0, 1'b1);        // drain
      drive(~tog_in, 1, 1'b0, 1'b0);       // capture 1 -> 2'b11
      drive(tog_in, 0, 1'b0, 1'b0);        // hold
      drive(~tog_in, 0, 1'b0, 1'b0);       // dropped, overrun
      drive(tog_in, 0, 1'b0, 1'b1);        // accept, no edge -> empty
      drive(tog_in, 0, 1'b0, 1'b0);
      drive(~tog_in, 0, 1'b0, 1'b0);       // capture 0 -> 2'b00
      drive(~tog_in, 1, 1'b0, 1'b1);       // accept and reload
      drive(~tog_in, 1, 1'b1, 1'b0);       // clr with edge and drop
      drive(tog_in, 0, 1'b0, 1'b1);

      // Saturation: many edges, then clr together with an edge.
      for (int i = 0; i < 20; i++) drive(~tog_in, $urandom_range(1, 0), 1'b0, 1'b1);
      drive(~tog_in, 1, 1'b1, 1'b1);
      drive(tog_in, 0, 1'b0, 1'b1);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(99, 0) < 60) ? ~tog_in : tog_in,
               $urandom_range(1, 0),
               ($urandom_range(99, 0) < 8),
               ($urandom_range(99, 0) < 50));
      end

      // Asynchronous reset between clock edges, mid-handshake.
      tog_in = ~tog_in; out_ready = 1'b0;
      @(posedge clk);
      model_step(~tog_in, int'(din), clr, out_ready);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      compare_all();
      tog_in = 1'b0; clr = 1'b0;
      @(negedge clk);
      compare_all();
      rst_n = 1'b1;
      run_toggler(24);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
